// File: rtl/grad_dac_serialiser.sv
// SPI serialiser for the gradient DACs: shifts one latched word MSB-first to every
// masked channel in parallel over a shared SCLK, then enforces a CS_N high gap.
module grad_dac_serialiser #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned DIV_W   = 6,
  parameter int unsigned MIN_GAP = 4
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [WORD_W-1:0] data_i,
  input  logic [N_CH-1:0]   valid_i,
  input  logic [DIV_W-1:0]  spi_clk_div_i,
  output logic              busy_o,
  output logic              data_lost_o,
  output logic              sclk_o,
  output logic [N_CH-1:0]   cs_n_o,
  output logic [N_CH-1:0]   sdo_o
);

  localparam int unsigned BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned GAP_W  = $clog2(MIN_GAP + 1);
  localparam int unsigned CNT_W  = (DIV_W > GAP_W) ? DIV_W : GAP_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]        r_state, w_state_nx;
  logic [CNT_W-1:0]  r_hcnt, w_hcnt_nx;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nx;
  logic [WORD_W-1:0] r_shreg, w_shreg_nx;
  logic [N_CH-1:0]   r_mask, w_mask_nx;
  logic [DIV_W-1:0]  r_div, w_div_nx;
  logic              r_sclk, w_sclk_nx;
  logic              r_busy, w_busy_nx;
  logic              r_lost, w_lost_nx;
  logic [N_CH-1:0]   r_cs_n, w_cs_n_nx;
  logic [N_CH-1:0]   r_sdo, w_sdo_nx;
  logic              w_active;

  // Next-state and next-output logic; outputs are registered from the next-state values
  always_comb begin
    w_state_nx = r_state;
    w_hcnt_nx  = r_hcnt;
    w_bcnt_nx  = r_bcnt;
    w_shreg_nx = r_shreg;
    w_mask_nx  = r_mask;
    w_div_nx   = r_div;
    w_sclk_nx  = r_sclk;

    case (r_state)
      S_IDLE: begin
        if (|valid_i) begin
          w_state_nx = S_SETUP;
          w_shreg_nx = data_i;
          w_mask_nx  = valid_i;
          w_div_nx   = spi_clk_div_i;
          w_hcnt_nx  = CNT_W'(spi_clk_div_i);
          w_bcnt_nx  = '0;
          w_sclk_nx  = 1'b0;
        end
      end
      S_SETUP: begin
        if (r_hcnt == '0) begin
          w_state_nx = S_SHIFT;
          w_sclk_nx  = 1'b1;
          w_hcnt_nx  = CNT_W'(r_div);
        end else begin
          w_hcnt_nx = r_hcnt - CNT_W'(1);
        end
      end
      S_SHIFT: begin
        // r_sclk doubles as the phase flag: high phase then low phase per bit
        if (r_hcnt != '0) begin
          w_hcnt_nx = r_hcnt - CNT_W'(1);
        end else if (r_sclk) begin
          w_sclk_nx  = 1'b0;
          w_shreg_nx = {r_shreg[WORD_W-2:0], 1'b0};
          w_hcnt_nx  = CNT_W'(r_div);
        end else if (r_bcnt == BCNT_W'(WORD_W - 1)) begin
          w_state_nx = S_GAP;
          w_hcnt_nx  = CNT_W'(MIN_GAP - 1);
        end else begin
          w_bcnt_nx = r_bcnt + BCNT_W'(1);
          w_sclk_nx = 1'b1;
          w_hcnt_nx = CNT_W'(r_div);
        end
      end
      S_GAP: begin
        if (r_hcnt == '0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_hcnt_nx = r_hcnt - CNT_W'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    w_active  = (w_state_nx == S_SETUP) || (w_state_nx == S_SHIFT);
    w_busy_nx = (w_state_nx != S_IDLE);
    w_lost_nx = (r_state != S_IDLE) && (|valid_i);
    w_cs_n_nx = w_active ? ~w_mask_nx : '1;
    w_sdo_nx  = w_active ? (w_mask_nx & {N_CH{w_shreg_nx[WORD_W-1]}}) : '0;
    if (!w_active) begin
      w_sclk_nx = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_shreg <= '0;
      r_mask  <= '0;
      r_div   <= '0;
      r_sclk  <= 1'b0;
      r_busy  <= 1'b0;
      r_lost  <= 1'b0;
      r_cs_n  <= '1;
      r_sdo   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_hcnt  <= w_hcnt_nx;
      r_bcnt  <= w_bcnt_nx;
      r_shreg <= w_shreg_nx;
      r_mask  <= w_mask_nx;
      r_div   <= w_div_nx;
      r_sclk  <= w_sclk_nx;
      r_busy  <= w_busy_nx;
      r_lost  <= w_lost_nx;
      r_cs_n  <= w_cs_n_nx;
      r_sdo   <= w_sdo_nx;
    end
  end

  assign busy_o      = r_busy;
  assign data_lost_o = r_lost;
  assign sclk_o      = r_sclk;
  assign cs_n_o      = r_cs_n;
  assign sdo_o       = r_sdo;

endmodule

// File: tb/tb_grad_dac_serialiser.sv
// Bench for grad_dac_serialiser: frame-level model compared every cycle, plus
// directed frames with hand-computed word/length expectations.
module tb_grad_dac_serialiser;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [3:0]  valid;
  logic [5:0]  div;
  logic        busy_o, data_lost_o, sclk_o;
  logic [3:0]  cs_n_o, sdo_o;

  int n_checks = 0;
  int n_err    = 0;

  grad_dac_serialiser dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .data_i       (data),
    .valid_i      (valid),
    .spi_clk_div_i(div),
    .busy_o       (busy_o),
    .data_lost_o  (data_lost_o),
    .sclk_o       (sclk_o),
    .cs_n_o       (cs_n_o),
    .sdo_o        (sdo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: an accepted frame is a schedule indexed by cycle offset
  logic        m_act, m_lost;
  int          m_off, m_h, m_len;
  logic [31:0] m_word;
  logic [3:0]  m_mask;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_lost <= 1'b0;
      m_off  <= 0;
    end else begin
      m_lost <= m_act && (|valid);
      if (m_act) begin
        if (m_off == m_len - 1) m_act <= 1'b0;
        else m_off <= m_off + 1;
      end else if (|valid) begin
        m_act  <= 1'b1;
        m_off  <= 0;
        m_h    <= int'(div) + 1;
        m_len  <= 65 * (int'(div) + 1) + 4;
        m_word <= data;
        m_mask <= valid;
      end
    end
  end

  // Compare process: every cycle, sampled on the falling clock edge
  always @(negedge clk) begin : cmp
    int s, b, falls;
    logic hi, bv, e_sclk;
    logic [3:0] e_cs, e_sdo;
    e_cs = 4'hF; e_sdo = 4'h0; e_sclk = 1'b0;
    if (m_act) begin
      if (m_off < m_h) begin
        e_cs  = ~m_mask;
        e_sdo = m_mask & {4{m_word[31]}};
      end else if (m_off < 65 * m_h) begin
        s     = m_off - m_h;
        b     = s / (2 * m_h);
        hi    = (s % (2 * m_h)) < m_h;
        falls = hi ? b : b + 1;
        bv    = (falls < 32) ? m_word[31 - falls] : 1'b0;
        e_cs  = ~m_mask;
        e_sclk = hi;
        e_sdo = m_mask & {4{bv}};
      end
    end
    check("busy", 32'(busy_o), 32'(m_act));
    check("data_lost", 32'(data_lost_o), 32'(m_lost));
    check("sclk", 32'(sclk_o), 32'(e_sclk));
    check("cs_n", 32'(cs_n_o), 32'(e_cs));
    check("sdo", 32'(sdo_o), 32'(e_sdo));
  end

  // Frame monitor: DAC-side capture on SCLK rise plus duration counters
  logic [31:0] cap [4];
  int cs_low [4];
  int rises, busy_cnt, frames, lost_cnt;
  logic p_busy, p_sclk;
  initial begin
    rises = 0; busy_cnt = 0; frames = 0; lost_cnt = 0; p_busy = 1'b0; p_sclk = 1'b0;
    for (int k = 0; k < 4; k++) begin cap[k] = '0; cs_low[k] = 0; end
  end

  always @(negedge clk) begin
    if (busy_o && !p_busy) begin
      frames++;
      rises = 0;
      busy_cnt = 0;
      for (int k = 0; k < 4; k++) begin cap[k] = '0; cs_low[k] = 0; end
    end
    if (busy_o) busy_cnt++;
    if (sclk_o && !p_sclk) begin
      rises++;
      for (int k = 0; k < 4; k++) cap[k] = {cap[k][30:0], sdo_o[k]};
    end
    for (int k = 0; k < 4; k++) if (!cs_n_o[k]) cs_low[k]++;
    if (data_lost_o) lost_cnt++;
    p_busy = busy_o;
    p_sclk = sclk_o;
  end

  task automatic send(input logic [31:0] d, input logic [3:0] v, input logic [5:0] dv);
    @(negedge clk);
    data = d; valid = v; div = dv;
    @(negedge clk);
    valid = 4'h0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy_o && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  int f0, l0;

  initial begin
    rst_n = 1'b1; data = '0; valid = '0; div = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_sclk", 32'(sclk_o), 32'd0);
    check("rst_cs_n", 32'(cs_n_o), 32'hF);
    check("rst_sdo", 32'(sdo_o), 32'd0);
    check("rst_lost", 32'(data_lost_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: fastest SCLK, all channels
    send(32'hABCD0123, 4'hF, 6'd0);
    wait_idle(3000);
    check("t1_rises", 32'(rises), 32'd32);
    for (int k = 0; k < 4; k++) check("t1_word", cap[k], 32'hABCD0123);
    check("t1_cs_low", 32'(cs_low[0]), 32'd65);
    check("t1_busy", 32'(busy_cnt), 32'd69);

    // 2: H=31, channels 0 and 2 only
    send(32'h12345678, 4'b0101, 6'd30);
    wait_idle(3000);
    check("t2_cs0", 32'(cs_low[0]), 32'd2015);
    check("t2_cs2", 32'(cs_low[2]), 32'd2015);
    check("t2_cs1", 32'(cs_low[1]), 32'd0);
    check("t2_cs3", 32'(cs_low[3]), 32'd0);
    check("t2_w0", cap[0], 32'h12345678);
    check("t2_w2", cap[2], 32'h12345678);
    check("t2_w1", cap[1], 32'h0);
    check("t2_w3", cap[3], 32'h0);
    check("t2_busy", 32'(busy_cnt), 32'd2019);

    // 3: strobe mid-frame is dropped with a single lost pulse
    f0 = frames; l0 = lost_cnt;
    send(32'h5A5AC3C3, 4'h8, 6'd2);
    repeat (40) @(negedge clk);
    data = 32'hFFFFFFFF; valid = 4'h1;
    @(negedge clk);
    valid = 4'h0;
    wait_idle(3000);
    repeat (10) @(negedge clk);
    check("t3_lost", 32'(lost_cnt - l0), 32'd1);
    check("t3_frames", 32'(frames - f0), 32'd1);
    check("t3_word", cap[3], 32'h5A5AC3C3);
    check("t3_cs3", 32'(cs_low[3]), 32'd195);
    check("t3_cs0", 32'(cs_low[0]), 32'd0);

    // 4: back-to-back accept in the first idle cycle
    send(32'h0F1E2D3C, 4'h3, 6'd0);
    wait_idle(3000);
    check("t4_wa", cap[1], 32'h0F1E2D3C);
    data = 32'h96C3A55A; valid = 4'h3;
    @(negedge clk);
    valid = 4'h0;
    check("t4_busy_next", 32'(busy_o), 32'd1);
    wait_idle(3000);
    check("t4_wb0", cap[0], 32'h96C3A55A);
    check("t4_wb1", cap[1], 32'h96C3A55A);
    check("t4_busy", 32'(busy_cnt), 32'd69);

    // 5: divisor change mid-frame only affects the next frame
    send(32'h3C3C_0FF0, 4'h1, 6'd30);
    repeat (100) @(negedge clk);
    div = 6'd0;
    wait_idle(3000);
    check("t5_busy_a", 32'(busy_cnt), 32'd2019);
    check("t5_wa", cap[0], 32'h3C3C_0FF0);
    send(32'hC0FFEE11, 4'h1, 6'd0);
    wait_idle(3000);
    check("t5_busy_b", 32'(busy_cnt), 32'd69);
    check("t5_wb", cap[0], 32'hC0FFEE11);

    // 6: async reset at bit 10, then a clean frame
    send(32'h0F0F00FF, 4'hF, 6'd0);
    begin
      int n;
      n = 0;
      while (rises < 11 && n < 500) begin @(negedge clk); n++; end
      if (rises < 11) check("t6_timeout", 32'(rises), 32'd11);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_sclk", 32'(sclk_o), 32'd0);
    check("t6_cs_n", 32'(cs_n_o), 32'hF);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_sdo", 32'(sdo_o), 32'd0);
    l0 = lost_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'hCAFEBEEF, 4'hF, 6'd0);
    wait_idle(3000);
    for (int k = 0; k < 4; k++) check("t6_word", cap[k], 32'hCAFEBEEF);
    check("t6_rises", 32'(rises), 32'd32);
    check("t6_nolost", 32'(lost_cnt - l0), 32'd0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
